// File: rtl/axi_pkg.sv
// Shared AXI4 constants and refill-FSM types for the I-cache refill master.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] LINE_LEN       = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AR    = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } refill_state_e;

    // A beat is bad when the slave reports a non-OKAY response or when RLAST
    // disagrees with the beat position (early, or missing on the final beat).
    function automatic logic beat_err(input logic [1:0] rresp,
                                      input logic       rlast,
                                      input logic [1:0] beat_cnt);
        logic is_last_s;
        is_last_s = (beat_cnt == LINE_LEN[1:0]);
        return (rresp != AXI_RESP_OKAY) || (rlast != is_last_s);
    endfunction

endpackage

// File: rtl/icache_refill_axi_master.sv
// I-cache line refill master: one 4-beat INCR AXI4 read burst per request,
// beats assembled into a 128-bit line returned with an error flag.
// Optional build macro ICACHE_REFILL_PERF_EN adds refill / stall counters.
module icache_refill_axi_master
    import axi_pkg::*;
#(
    parameter int WIDTH_AD   = 32,
    parameter int WIDTH_DA   = 32,
    parameter int LINE_BEATS = 4
) (
    input  logic                         M_AXI_ACLK,
    input  logic                         M_AXI_ARESET,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [WIDTH_AD-1:0]          req_addr,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [WIDTH_DA*LINE_BEATS-1:0] resp_line,
    output logic                         resp_err,
    output logic [WIDTH_AD-1:0]          M_AXI_ARADDR,
    output logic [3:0]                   M_AXI_ARLEN,
    output logic [2:0]                   M_AXI_ARSIZE,
    output logic [1:0]                   M_AXI_ARBURST,
    output logic                         M_AXI_ARVALID,
    input  logic                         M_AXI_ARREADY,
    input  logic [WIDTH_DA-1:0]          M_AXI_RDATA,
    input  logic [1:0]                   M_AXI_RRESP,
    input  logic                         M_AXI_RLAST,
    input  logic                         M_AXI_RVALID,
    output logic                         M_AXI_RREADY
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]                  perf_refills,
    output logic [31:0]                  perf_stall_cycles
`endif
);

    localparam int LINE_W = WIDTH_DA * LINE_BEATS;

    // Line-aligned address mask: the low 16 bytes select within the line.
    localparam logic [WIDTH_AD-1:0] LINE_MASK = {{(WIDTH_AD-4){1'b1}}, 4'b0000};

    refill_state_e         state_r, state_nxt_s;
    logic [1:0]            beat_cnt_r, beat_cnt_nxt_s;
    logic [WIDTH_AD-1:0]   araddr_r, araddr_nxt_s;
    logic                  arvalid_r, arvalid_nxt_s;
    logic                  rready_r, rready_nxt_s;
    logic                  req_ready_r, req_ready_nxt_s;
    logic                  resp_valid_r, resp_valid_nxt_s;
    logic                  resp_err_r, resp_err_nxt_s;
    logic [LINE_W-1:0]     resp_line_r, resp_line_nxt_s;

    // Next-state and next-output computation; every output is a register fed from here.
    always_comb begin
        state_nxt_s      = state_r;
        beat_cnt_nxt_s   = beat_cnt_r;
        araddr_nxt_s     = araddr_r;
        arvalid_nxt_s    = arvalid_r;
        rready_nxt_s     = rready_r;
        req_ready_nxt_s  = req_ready_r;
        resp_valid_nxt_s = resp_valid_r;
        resp_err_nxt_s   = resp_err_r;
        resp_line_nxt_s  = resp_line_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s     = AR;
                    araddr_nxt_s    = req_addr & LINE_MASK;
                    resp_err_nxt_s  = 1'b0;
                    arvalid_nxt_s   = 1'b1;
                    req_ready_nxt_s = 1'b0;
                end else begin
                    req_ready_nxt_s = 1'b1;
                end
            end
            AR: begin
                if (M_AXI_ARREADY) begin
                    state_nxt_s   = RDATA;
                    arvalid_nxt_s = 1'b0;
                    rready_nxt_s  = 1'b1;
                end else begin
                    arvalid_nxt_s = 1'b1;
                end
            end
            RDATA: begin
                if (M_AXI_RVALID && rready_r) begin
                    resp_line_nxt_s[{beat_cnt_r, 5'b00000} +: WIDTH_DA] = M_AXI_RDATA;
                    beat_cnt_nxt_s = beat_cnt_r + 2'd1;
                    if (beat_err(M_AXI_RRESP, M_AXI_RLAST, beat_cnt_r)) begin
                        resp_err_nxt_s = 1'b1;
                    end else begin
                        resp_err_nxt_s = resp_err_r;
                    end
                    // The line always ends after four beats, whatever RLAST says.
                    if (beat_cnt_r == LINE_LEN[1:0]) begin
                        state_nxt_s      = RESP;
                        rready_nxt_s     = 1'b0;
                        resp_valid_nxt_s = 1'b1;
                    end else begin
                        rready_nxt_s = 1'b1;
                    end
                end else begin
                    rready_nxt_s = 1'b1;
                end
            end
            RESP: begin
                if (resp_valid_r && resp_ready) begin
                    state_nxt_s      = IDLE;
                    resp_valid_nxt_s = 1'b0;
                    req_ready_nxt_s  = 1'b1;
                end else begin
                    resp_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s      = IDLE;
                beat_cnt_nxt_s   = 2'd0;
                arvalid_nxt_s    = 1'b0;
                rready_nxt_s     = 1'b0;
                resp_valid_nxt_s = 1'b0;
                req_ready_nxt_s  = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset; outstanding beats are abandoned on reset.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_r      <= IDLE;
            beat_cnt_r   <= 2'd0;
            araddr_r     <= '0;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_line_r  <= '0;
        end else begin
            state_r      <= state_nxt_s;
            beat_cnt_r   <= beat_cnt_nxt_s;
            araddr_r     <= araddr_nxt_s;
            arvalid_r    <= arvalid_nxt_s;
            rready_r     <= rready_nxt_s;
            req_ready_r  <= req_ready_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
            resp_line_r  <= resp_line_nxt_s;
        end
    end

    assign req_ready     = req_ready_r;
    assign resp_valid    = resp_valid_r;
    assign resp_line     = resp_line_r;
    assign resp_err      = resp_err_r;
    assign M_AXI_ARADDR  = araddr_r;
    assign M_AXI_ARLEN   = LINE_LEN;
    assign M_AXI_ARSIZE  = AXI_SIZE_4B;
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_RREADY  = rready_r;

`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] perf_refills_r;
    logic [31:0] perf_stall_cycles_r;

    // Count delivered lines and cycles spent waiting on the slave (AR or R channel).
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            perf_refills_r      <= 32'd0;
            perf_stall_cycles_r <= 32'd0;
        end else begin
            if (resp_valid_r && resp_ready) begin
                perf_refills_r <= perf_refills_r + 32'd1;
            end else begin
                perf_refills_r <= perf_refills_r;
            end
            if (((state_r == AR) && !M_AXI_ARREADY) ||
                ((state_r == RDATA) && !M_AXI_RVALID)) begin
                perf_stall_cycles_r <= perf_stall_cycles_r + 32'd1;
            end else begin
                perf_stall_cycles_r <= perf_stall_cycles_r;
            end
        end
    end

    assign perf_refills      = perf_refills_r;
    assign perf_stall_cycles = perf_stall_cycles_r;
`endif

endmodule

// File: tb/tb_icache_refill_axi_master.sv
// Directed + randomized bench for icache_refill_axi_master; the expected line
// and error flag come from a per-refill beat list modelled inside the bench.
module tb_icache_refill_axi_master;

    logic         M_AXI_ACLK = 1'b0;
    logic         M_AXI_ARESET;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_line;
    logic         resp_err;
    logic [31:0]  M_AXI_ARADDR;
    logic [3:0]   M_AXI_ARLEN;
    logic [2:0]   M_AXI_ARSIZE;
    logic [1:0]   M_AXI_ARBURST;
    logic         M_AXI_ARVALID;
    logic         M_AXI_ARREADY;
    logic [31:0]  M_AXI_RDATA;
    logic [1:0]   M_AXI_RRESP;
    logic         M_AXI_RLAST;
    logic         M_AXI_RVALID;
    logic         M_AXI_RREADY;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    icache_refill_axi_master dut (
        .M_AXI_ACLK   (M_AXI_ACLK),
        .M_AXI_ARESET (M_AXI_ARESET),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_line    (resp_line),
        .resp_err     (resp_err),
        .M_AXI_ARADDR (M_AXI_ARADDR),
        .M_AXI_ARLEN  (M_AXI_ARLEN),
        .M_AXI_ARSIZE (M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA  (M_AXI_RDATA),
        .M_AXI_RRESP  (M_AXI_RRESP),
        .M_AXI_RLAST  (M_AXI_RLAST),
        .M_AXI_RVALID (M_AXI_RVALID),
        .M_AXI_RREADY (M_AXI_RREADY)
    );

    always #5 M_AXI_ACLK = ~M_AXI_ACLK;

    // Edge counter used for latency measurement.
    always @(posedge M_AXI_ACLK) cyc = cyc + 1;

    task automatic tick();
        @(posedge M_AXI_ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One complete refill: drives the request and a slave with the given
    // behaviour, and compares against a line/err computed from the beat list.
    task automatic do_refill(input logic [31:0] addr, input bit fixed_data,
                             input int ar_wait, input logic [7:0] rresps,
                             input logic [3:0] rlast_mask, input int max_gap,
                             input int resp_wait);
        logic [31:0]  beats [4];
        logic [127:0] exp_line;
        logic         exp_err;
        logic [31:0]  exp_araddr;
        int           acc;
        int           gaps;
        int           g;
        for (int k = 0; k < 4; k++) begin
            if (fixed_data) beats[k] = 32'h1111_1111 * (k + 1);
            else            beats[k] = $urandom;
        end
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        exp_err  = (rlast_mask != 4'b1000);
        for (int k = 0; k < 4; k++) begin
            if (rresps[2*k +: 2] != 2'b00) exp_err = 1'b1;
        end
        exp_araddr = {addr[31:4], 4'h0};

        check("req_ready_idle", req_ready, 1'b1);
        req_addr  = addr;
        req_valid = 1'b1;
        tick();
        acc       = cyc;
        req_valid = 1'b0;
        req_addr  = $urandom;
        check("arvalid_set", M_AXI_ARVALID, 1'b1);
        check("araddr", M_AXI_ARADDR, exp_araddr);
        check("arlen", M_AXI_ARLEN, 4'd3);
        check("arsize", M_AXI_ARSIZE, 3'b010);
        check("arburst", M_AXI_ARBURST, 2'b01);
        check("req_ready_busy", req_ready, 1'b0);
        for (int i = 0; i < ar_wait; i++) begin
            M_AXI_ARREADY = 1'b0;
            tick();
            check("arvalid_hold", M_AXI_ARVALID, 1'b1);
            check("araddr_hold", M_AXI_ARADDR, exp_araddr);
        end
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        check("arvalid_drop", M_AXI_ARVALID, 1'b0);
        check("rready_set", M_AXI_RREADY, 1'b1);

        gaps = 0;
        for (int k = 0; k < 4; k++) begin
            g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            for (int j = 0; j < g; j++) begin
                M_AXI_RVALID = 1'b0;
                tick();
                gaps++;
                check("rready_gap", M_AXI_RREADY, 1'b1);
            end
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = beats[k];
            M_AXI_RRESP  = rresps[2*k +: 2];
            M_AXI_RLAST  = rlast_mask[k];
            tick();
            M_AXI_RVALID = 1'b0;
            M_AXI_RLAST  = 1'b0;
            M_AXI_RRESP  = 2'b00;
            M_AXI_RDATA  = $urandom;
            if (k < 3) check("no_early_resp", resp_valid, 1'b0);
        end
        check("resp_valid", resp_valid, 1'b1);
        check("rready_drop", M_AXI_RREADY, 1'b0);
        check("resp_line", resp_line, exp_line);
        check("resp_err", resp_err, exp_err);
        // Accept edge ends cycle N; resp_valid is visible in cycle N+6, i.e.
        // five edges later with a zero-wait slave, plus any inserted waits.
        check("latency", cyc - acc, 5 + ar_wait + gaps);

        for (int i = 0; i < resp_wait; i++) begin
            resp_ready = 1'b0;
            req_valid  = 1'b1;
            req_addr   = $urandom;
            tick();
            check("resp_valid_hold", resp_valid, 1'b1);
            check("resp_line_hold", resp_line, exp_line);
            check("resp_err_hold", resp_err, exp_err);
            check("req_ready_resp", req_ready, 1'b0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_valid_clr", resp_valid, 1'b0);
        check("req_ready_back", req_ready, 1'b1);
    endtask

    initial begin
        M_AXI_ARESET  = 1'b1;
        req_valid     = 1'b0;
        req_addr      = 32'h0;
        resp_ready    = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RDATA   = 32'h0;
        M_AXI_RRESP   = 2'b00;
        M_AXI_RLAST   = 1'b0;
        M_AXI_RVALID  = 1'b0;
        tick();
        tick();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_arvalid", M_AXI_ARVALID, 1'b0);
        check("rst_rready", M_AXI_RREADY, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_line", resp_line, 128'h0);
        check("rst_araddr", M_AXI_ARADDR, 32'h0);
        M_AXI_ARESET = 1'b0;
        tick();

        // Basic zero-wait refill with known beat pattern.
        do_refill(32'h0000_1234, 1'b1, 0, 8'h00, 4'b1000, 0, 0);
        check("basic_line_const", resp_line, 128'h44444444_33333333_22222222_11111111);
        // AR stalled five cycles.
        do_refill($urandom, 1'b0, 5, 8'h00, 4'b1000, 0, 0);
        // SLVERR on beat 2 only.
        do_refill($urandom, 1'b0, 0, 8'b0000_1000, 4'b1000, 0, 0);
        // Early RLAST on beat 3, then RLAST missing altogether.
        do_refill($urandom, 1'b0, 0, 8'h00, 4'b0100, 0, 0);
        do_refill($urandom, 1'b0, 0, 8'h00, 4'b0000, 0, 0);
        // Cache back-pressure, followed by an immediate new request.
        do_refill($urandom, 1'b0, 0, 8'h00, 4'b1000, 0, 10);
        do_refill($urandom, 1'b0, 0, 8'h00, 4'b1000, 0, 0);

        // Reset after two beats, then a clean refill.
        req_addr  = 32'h0000_5678;
        req_valid = 1'b1;
        tick();
        req_valid     = 1'b0;
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        for (int k = 0; k < 2; k++) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = $urandom;
            M_AXI_RRESP  = 2'b10;
            tick();
        end
        M_AXI_RVALID = 1'b0;
        M_AXI_RRESP  = 2'b00;
        M_AXI_ARESET = 1'b1;
        tick();
        M_AXI_ARESET = 1'b0;
        check("mid_rst_rready", M_AXI_RREADY, 1'b0);
        check("mid_rst_resp_valid", resp_valid, 1'b0);
        check("mid_rst_req_ready", req_ready, 1'b1);
        check("mid_rst_arvalid", M_AXI_ARVALID, 1'b0);
        check("mid_rst_resp_err", resp_err, 1'b0);
        do_refill(32'h0000_9ABC, 1'b0, 0, 8'h00, 4'b1000, 0, 0);

        // Randomized refills with slave stalls and occasional bad responses.
        for (int t = 0; t < 8; t++) begin
            logic [7:0] rr;
            logic [3:0] lm;
            rr = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h00;
            lm = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'b1000;
            do_refill($urandom, 1'b0, $urandom_range(3, 0), rr, lm, 3, $urandom_range(3, 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
